// File: rtl/pi_channel_scheduler.sv
// Time-multiplexes NCH PI channels onto one shared PI datapath per simulation step.
// Issues enabled channels in ascending order, tracks results by tag, commits x/y history.

module pi_ch_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        wr,
  input  logic        cm,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic [31:0] x_lat,
  output logic [31:0] x_prev,
  output logic [31:0] y_prev,
  output logic [31:0] y
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_lat  <= '0;
      x_prev <= '0;
      y_prev <= '0;
      y      <= '0;
    end else begin
      if (ld) x_lat <= x_in;
      if (wr) y <= y_in;
      if (cm) begin
        x_prev <= x_lat;
        y_prev <= y;
      end
    end
  end
endmodule

module pi_channel_scheduler #(
  parameter int NCH = 4,
  parameter int LAT = 20,
  parameter int TMO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_start,
  input  logic [NCH-1:0]    ch_en,
  input  logic [32*NCH-1:0] x_in,
  output logic              pi_sta,
  output logic [31:0]       pi_x,
  output logic [31:0]       pi_x_prev,
  output logic [31:0]       pi_y_prev,
  input  logic              pi_done,
  input  logic [31:0]       pi_y,
  output logic [32*NCH-1:0] y_out,
  output logic              step_done,
  output logic              step_ok,
  output logic              busy,
  output logic [2:0]        err
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(NCH + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0]        pend, en_q, issue_oh;
  logic [PW-1:0]         sel, wr_ptr, rd_ptr, tag;
  logic [PW-1:0]         tagq [NCH];
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [TW-1:0]         wcnt;
  logic                  push, pop, tmo, accept, fin_q, fok_q;
  logic [NCH-1:0][31:0]  x_lat, x_prv, y_prv, y_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(NCH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest pending channel goes next; issue_oh isolates that bit.
  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (pend[i]) sel = PW'(i);
  end
  assign issue_oh = pend & ~(pend - 1'b1);

  assign accept  = (state == IDLE) && step_start && (ch_en != '0);
  assign push    = (state == ISSUE);
  assign pop     = pi_done && (cnt != '0);
  assign tag     = tagq[rd_ptr];
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign tmo     = (state == WAIT) && !pop && (wcnt == TW'(TMO - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if ((pend & ~issue_oh) == '0) state_nxt = WAIT;
      WAIT:    if (tmo) state_nxt = IDLE;
               else if (cnt_nxt == '0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pend   <= '0;
      en_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      wcnt   <= '0;
      fin_q  <= 1'b0;
      fok_q  <= 1'b0;
      err    <= '0;
      for (int i = 0; i < NCH; i++) tagq[i] <= '0;
    end else begin
      state <= state_nxt;
      fin_q <= ((state == IDLE) && step_start && (ch_en == '0)) || tmo;
      fok_q <= (state == IDLE) && step_start && (ch_en == '0);
      if (accept) begin
        pend <= ch_en;
        en_q <= ch_en;
      end else if (push) begin
        pend <= pend & ~issue_oh;
      end
      // A timeout drops every outstanding tag; late results then flag err[1].
      if (tmo) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          tagq[wr_ptr] <= sel;
          wr_ptr       <= inc(wr_ptr);
        end
        if (pop) rd_ptr <= inc(rd_ptr);
        cnt <= cnt_nxt;
      end
      wcnt <= ((state != WAIT) || pop) ? '0 : wcnt + 1'b1;
      err  <= err | {tmo, pi_done && (cnt == '0), step_start && (state != IDLE)};
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pi_ch_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .ld     (accept),
      .wr     (pop && (tag == PW'(k))),
      .cm     ((state == COMMIT) && en_q[k]),
      .x_in   (x_in[32*k +: 32]),
      .y_in   (pi_y),
      .x_lat  (x_lat[k]),
      .x_prev (x_prv[k]),
      .y_prev (y_prv[k]),
      .y      (y_q[k])
    );
  end

  assign pi_sta    = push;
  assign pi_x      = x_lat[sel];
  assign pi_x_prev = x_prv[sel];
  assign pi_y_prev = y_prv[sel];
  assign y_out     = y_q;
  assign step_done = (state == COMMIT) || fin_q;
  assign step_ok   = (state == COMMIT) || fok_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_pi_channel_scheduler.sv
// Directed bench for pi_channel_scheduler with a fixed-latency datapath model.
module tb_pi_channel_scheduler;
  localparam int NCH = 4;
  localparam int LAT = 20;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              step_start = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic [32*NCH-1:0] x_in = '0;
  logic              pi_sta, pi_done, step_done, step_ok, busy;
  logic [31:0]       pi_x, pi_x_prev, pi_y_prev, pi_y;
  logic [32*NCH-1:0] y_out;
  logic [2:0]        err;
  logic              mute = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] xp [NCH];
  logic [31:0] yp [NCH];
  logic [31:0] ye [NCH];

  pi_channel_scheduler #(.NCH(NCH), .LAT(LAT), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .ch_en(ch_en), .x_in(x_in),
    .pi_sta(pi_sta), .pi_x(pi_x), .pi_x_prev(pi_x_prev), .pi_y_prev(pi_y_prev),
    .pi_done(pi_done), .pi_y(pi_y), .y_out(y_out), .step_done(step_done),
    .step_ok(step_ok), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pif(input logic [31:0] x, input logic [31:0] xpv, input logic [31:0] ypv);
    return x + (ypv << 1) - xpv;
  endfunction

  // Datapath model: fixed LAT-cycle pipeline from pi_sta to pi_done.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    py [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], pi_sta};
    py[0] <= pif(pi_x, pi_x_prev, pi_y_prev);
    for (int i = 1; i < LAT; i++) py[i] <= py[i-1];
  end
  assign pi_done = pv[LAT-1] & ~mute;
  assign pi_y    = py[LAT-1];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag);
    for (int k = 0; k < NCH; k++) chk(tag, y_out[32*k +: 32], ye[k]);
  endtask

  task automatic run_step(input logic [NCH-1:0] en, input logic [NCH-1:0][31:0] x,
                          input int exp_cyc, input logic exp_ok, input int poke);
    int nxt;
    int n_iss;
    logic seen;
    logic [NCH-1:0] rem;
    rem = en; n_iss = 0; seen = 1'b0;
    ch_en = en; x_in = x; step_start = 1'b1;
    for (int c = 1; c <= 200 && !seen; c++) begin
      cyc();
      step_start = (c == poke);
      if (c == poke) ch_en = 4'hF;
      if (pi_sta) begin
        nxt = -1;
        for (int k = NCH - 1; k >= 0; k--) if (rem[k]) nxt = k;
        if (nxt < 0) chk("iss_extra", 32'd1, 32'd0);
        else begin
          chk("iss_cyc", c, n_iss + 1);
          chk("pi_x", pi_x, x[nxt]);
          chk("pi_x_prev", pi_x_prev, xp[nxt]);
          chk("pi_y_prev", pi_y_prev, yp[nxt]);
          rem[nxt] = 1'b0;
        end
        n_iss++;
      end
      if (step_done) begin
        seen = 1'b1;
        chk("done_cyc", c, exp_cyc);
        chk("step_ok", step_ok, exp_ok);
      end
    end
    step_start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("iss_cnt", n_iss, $countones(en));
    if (exp_ok)
      for (int k = 0; k < NCH; k++) if (en[k]) ye[k] = pif(x[k], xp[k], yp[k]);
    chk_y("y_out");
    if (exp_ok)
      for (int k = 0; k < NCH; k++) if (en[k]) begin xp[k] = x[k]; yp[k] = ye[k]; end
    cyc(); cyc();
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin xp[k] = '0; yp[k] = '0; ye[k] = '0; end
    repeat (3) cyc();
    chk("rst_pi_sta", pi_sta, 1'b0);
    chk("rst_step_done", step_done, 1'b0);
    chk("rst_step_ok", step_ok, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 3'b000);
    chk_y("rst_y_out");
    rst = 1'b1;
    cyc(); cyc();

    // All four channels, prevs start at zero.
    run_step(4'b1111, {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100}, 25, 1'b1, 0);
    // Sparse enable: 1 and 3 must keep their history.
    run_step(4'b0101, {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011}, 23, 1'b1, 0);
    // Empty step finishes next cycle without issuing.
    run_step(4'b0000, {32'h1, 32'h2, 32'h3, 32'h4}, 1, 1'b1, 0);
    // step_start during WAIT is flagged and ignored.
    run_step(4'b0001, {32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 32'h0000_0055}, 22, 1'b1, 5);
    chk("err0_set", err, 3'b001);
    // Lost result: timeout 64 cycles after WAIT entry, no commit.
    mute = 1'b1;
    run_step(4'b0010, {32'h9, 32'h9, 32'h0000_0999, 32'h9}, 2 + TMO, 1'b0, 0);
    chk("err2_set", err, 3'b101);
    mute = 1'b0;
    // Channel 1 history must still be from the sparse/full steps, not the aborted one.
    run_step(4'b0010, {32'h0, 32'h0, 32'h0000_0777, 32'h0}, 22, 1'b1, 0);

    // Reset in the middle of ISSUE.
    ch_en = 4'b1111; x_in = {32'h4, 32'h3, 32'h2, 32'h1}; step_start = 1'b1;
    cyc();
    step_start = 1'b0;
    chk("s6_issuing", pi_sta, 1'b1);
    cyc();
    rst = 1'b0;
    #1;
    chk("s6_pi_sta", pi_sta, 1'b0);
    chk("s6_busy", busy, 1'b0);
    chk("s6_step_done", step_done, 1'b0);
    chk("s6_err", err, 3'b000);
    for (int k = 0; k < NCH; k++) begin xp[k] = '0; yp[k] = '0; ye[k] = '0; end
    chk_y("s6_y_out");
    cyc(); cyc();
    rst = 1'b1;
    repeat (30) cyc();
    chk("s6_stray_err1", err, 3'b010);
    chk_y("s6_y_discard");
    run_step(4'b1111, {32'h0000_5000, 32'h0000_6000, 32'h0000_7000, 32'h0000_8000}, 25, 1'b1, 0);
    run_step(4'b1001, {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004}, 23, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
